fetch_ctrl: RTL and testbench

Sequencing controller for the instruction-fetch datapath of the single-cycle CPU. Each cycle it decodes the fetched instruction and the ALU zero flag into the fetch path's 2-bit next-PC select, and gates PC updates through a PC write enable. A four-state FSM covers boot hold, stall and halt/resume. It also maintains retired-instruction and taken-branch counters for debug.

---
 rtl/fetch_ctrl.sv | 121 ++++++++++++
 tb/tb_fetch_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl
//   Sequencing controller for the instruction-fetch path of a single-cycle CPU.
//   Decodes the fetched instruction and the ALU zero flag into a 2-bit next-PC
//   select, gates PC updates with a write enable, and runs a four-state FSM
//   covering boot hold, stall and halt/resume. It also keeps debug counters
//   for retired instructions and taken branches/jumps.
//
// Ports
//   clock          in   system clock, rising edge
//   reset          in   asynchronous active-high reset
//   inst[31:0]     in   instruction currently presented by the instruction ROM
//   zero           in   ALU zero flag for the current instruction
//   stall_req      in   level hazard/busy request, holds the PC while high
//   resume         in   single-cycle pulse that leaves HALT
//   pc_sel[1:0]    out  next-PC select: 0 = PC+4, 1 = branch target, 3 = jump target
//   pc_we          out  PC write enable
//   state[1:0]     out  FSM state: BOOT = 0, RUN = 1, STALL = 2, HALT = 3
//   halted         out  registered, high while in HALT
//   retired_count  out  cycles with pc_we = 1 (wraps)
//   taken_count    out  retired taken branches/jumps (saturates)
module fetch_ctrl #(
  parameter int BOOT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] inst,
  input  logic        zero,
  input  logic        stall_req,
  input  logic        resume,
  output logic [1:0]  pc_sel,
  output logic        pc_we,
  output logic [1:0]  state,
  output logic        halted,
  output logic [31:0] retired_count,
  output logic [15:0] taken_count
);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;

  localparam logic [31:0] HALT_INST = 32'h0000_000C;

  localparam logic [1:0] SEL_SEQ    = 2'd0;
  localparam logic [1:0] SEL_BRANCH = 2'd1;
  localparam logic [1:0] SEL_JUMP   = 2'd3;

  localparam logic [7:0] BOOT_LAST = 8'(BOOT_CYCLES - 1);

  // Saturating increment for the taken counter: sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [7:0] boot_cnt;
  logic [1:0] next_state;
  logic [1:0] dec_sel;
  logic       is_halt;

  // Decode: branch/jump select independent of FSM state.
  always_comb begin
    dec_sel = SEL_SEQ;
    is_halt = (inst == HALT_INST);
    case (inst[31:26])
      OP_BEQ:        dec_sel = zero  ? SEL_BRANCH : SEL_SEQ;
      OP_BNE:        dec_sel = !zero ? SEL_BRANCH : SEL_SEQ;
      OP_J, OP_JAL:  dec_sel = SEL_JUMP;
      default:       dec_sel = SEL_SEQ;
    endcase
  end

  // Outputs and next state. Stall outranks halt decode in RUN. In HALT the
  // resume cycle writes the PC with select 0 so it steps past the halt word.
  always_comb begin
    pc_sel     = SEL_SEQ;
    pc_we      = 1'b0;
    next_state = state;
    case (state)
      S_BOOT: begin
        if (boot_cnt == BOOT_LAST) next_state = S_RUN;
      end
      S_RUN: begin
        pc_sel = dec_sel;
        pc_we  = !stall_req && !is_halt;
        if (stall_req)    next_state = S_STALL;
        else if (is_halt) next_state = S_HALT;
      end
      S_STALL: begin
        if (!stall_req) next_state = S_RUN;
      end
      S_HALT: begin
        pc_we = resume;
        if (resume) next_state = S_RUN;
      end
      default: next_state = S_BOOT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= S_BOOT;
      halted        <= 1'b0;
      boot_cnt      <= 8'd0;
      retired_count <= 32'd0;
      taken_count   <= 16'd0;
    end else begin
      state  <= next_state;
      halted <= (next_state == S_HALT);
      if (state == S_BOOT) boot_cnt <= boot_cnt + 8'd1;
      if (pc_we) retired_count <= retired_count + 32'd1;
      if (pc_we && (pc_sel != SEL_SEQ)) taken_count <= sat_inc16(taken_count);
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: behavioural model checked every cycle plus
// hand-computed literal expectations.
module tb_fetch_ctrl;

  localparam int BOOT_CYCLES = 2;
  localparam logic [31:0] HALT_I = 32'h0000_000C;
  localparam logic [31:0] NOP_I  = 32'h0000_0020;
  localparam logic [31:0] BEQ_I  = 32'h1000_0005;
  localparam logic [31:0] BNE_I  = 32'h1400_0003;
  localparam logic [31:0] J_I    = 32'h0800_0010;
  localparam logic [31:0] JAL_I  = 32'h0C00_0004;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] inst;
  logic        zero;
  logic        stall_req;
  logic        resume;
  logic [1:0]  pc_sel;
  logic        pc_we;
  logic [1:0]  state;
  logic        halted;
  logic [31:0] retired_count;
  logic [15:0] taken_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: phase 0 boot, 1 run, 2 stall, 3 halt.
  int          m_state;
  int          m_boot;
  logic [31:0] m_ret;
  int          m_tak;

  fetch_ctrl #(.BOOT_CYCLES(BOOT_CYCLES)) dut (
    .clock(clock), .reset(reset), .inst(inst), .zero(zero),
    .stall_req(stall_req), .resume(resume), .pc_sel(pc_sel), .pc_we(pc_we),
    .state(state), .halted(halted), .retired_count(retired_count),
    .taken_count(taken_count)
  );

  always #5 clock = ~clock;

  function automatic int decode(input logic [31:0] i, input logic z);
    logic [5:0] op;
    op = i[31:26];
    if (op == 6'b000100) return z ? 1 : 0;
    if (op == 6'b000101) return z ? 0 : 1;
    if (op == 6'b000010 || op == 6'b000011) return 3;
    return 0;
  endfunction

  function automatic int exp_sel();
    return (m_state == 1) ? decode(inst, zero) : 0;
  endfunction

  function automatic bit exp_we();
    return (m_state == 1 && !stall_req && inst != HALT_I) || (m_state == 3 && resume);
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_state = 0;
      m_boot  = 0;
      m_ret   = 0;
      m_tak   = 0;
    end else begin
      int s;
      bit w;
      s = exp_sel();
      w = exp_we();
      if (w) begin
        m_ret = m_ret + 1;
        if (s != 0 && m_tak < 65535) m_tak++;
      end
      case (m_state)
        0: if (m_boot == BOOT_CYCLES - 1) m_state = 1; else m_boot++;
        1: if (stall_req) m_state = 2; else if (inst == HALT_I) m_state = 3;
        2: if (!stall_req) m_state = 1;
        3: if (resume) m_state = 1;
        default: m_state = 0;
      endcase
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clock) begin
    logic [53:0] a, e;
    a = {pc_sel, pc_we, state, halted, retired_count, taken_count};
    e = {2'(exp_sel()), exp_we(), 2'(m_state), (m_state == 3), m_ret, 16'(m_tak)};
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL cycle_compare t=%0t actual=%h required=%h", $time, a, e);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic z, input logic s, input logic r);
    inst = i; zero = z; stall_req = s; resume = r;
  endtask

  logic [31:0] ret0;
  logic [15:0] tk0;
  int          guard;

  initial begin
    reset = 1'b1;
    drive(NOP_I, 1'b0, 1'b0, 1'b0);
    #3;
    check("reset_state", 32'(state), 32'd0);
    check("reset_pc_we", 32'(pc_we), 32'd0);
    check("reset_retired", retired_count, 32'd0);
    #9 reset = 1'b0;                       // t=12, edges at 15,25 are BOOT
    @(negedge clock);
    check("boot_pc_we_0", 32'(pc_we), 32'd0);
    check("boot_state", 32'(state), 32'd0);
    @(negedge clock);
    check("run_pc_we_1", 32'(pc_we), 32'd1);
    check("run_state", 32'(state), 32'd1);
    repeat (3) @(posedge clock);
    #1;
    check("retired_after_5_edges", retired_count, 32'd3);

    // Branch / jump decode
    drive(BEQ_I, 1'b1, 1'b0, 1'b0);
    tk0 = taken_count;
    #3 check("beq_taken_sel", 32'(pc_sel), 32'd1);
    tick();
    check("beq_taken_count", 32'(taken_count), 32'(tk0 + 16'd1));
    drive(BEQ_I, 1'b0, 1'b0, 1'b0);
    #3 check("beq_not_taken_sel", 32'(pc_sel), 32'd0);
    tick();
    drive(BNE_I, 1'b0, 1'b0, 1'b0);
    #3 check("bne_taken_sel", 32'(pc_sel), 32'd1);
    tick();
    drive(J_I, 1'b0, 1'b0, 1'b0);
    tk0 = taken_count;
    #3 check("j_sel", 32'(pc_sel), 32'd3);
    check("j_we", 32'(pc_we), 32'd1);
    tick();
    check("j_taken_count", 32'(taken_count), 32'(tk0 + 16'd1));

    // Stall for three cycles
    drive(NOP_I, 1'b0, 1'b1, 1'b0);
    ret0 = retired_count;
    #3 check("stall_we_same_cycle", 32'(pc_we), 32'd0);
    tick();
    check("stall_state", 32'(state), 32'd2);
    tick();
    tick();
    drive(NOP_I, 1'b0, 1'b0, 1'b0);
    #3 check("stall_exit_we", 32'(pc_we), 32'd0);
    check("stall_exit_state", 32'(state), 32'd2);
    check("stall_retired_frozen", retired_count, ret0);
    tick();
    check("stall_back_to_run", 32'(state), 32'd1);

    // Halt and resume
    drive(HALT_I, 1'b0, 1'b0, 1'b0);
    #3 check("halt_we", 32'(pc_we), 32'd0);
    tick();
    check("halt_halted", 32'(halted), 32'd1);
    repeat (10) tick();
    check("halt_hold_state", 32'(state), 32'd3);
    drive(HALT_I, 1'b0, 1'b0, 1'b1);
    #3 check("resume_we", 32'(pc_we), 32'd1);
    check("resume_sel", 32'(pc_sel), 32'd0);
    tick();
    drive(NOP_I, 1'b0, 1'b0, 1'b0);
    check("resume_state", 32'(state), 32'd1);

    // Stall outranks halt decode
    drive(HALT_I, 1'b0, 1'b1, 1'b0);
    tick();
    check("stall_over_halt", 32'(state), 32'd2);
    drive(NOP_I, 1'b0, 1'b0, 1'b0);
    tick();

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] pick;
      case ($urandom_range(0, 7))
        0: pick = NOP_I;
        1: pick = BEQ_I;
        2: pick = BNE_I;
        3: pick = J_I;
        4: pick = JAL_I;
        5: pick = HALT_I;
        6: pick = 32'h8C00_0000;
        default: pick = 32'h0000_000D;
      endcase
      drive(pick, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 3) == 0));
      tick();
    end

    // Return to RUN, then saturate taken_count with jumps
    drive(NOP_I, 1'b0, 1'b0, 1'b1);
    tick();
    drive(NOP_I, 1'b0, 1'b0, 1'b0);
    tick();
    drive(J_I, 1'b0, 1'b0, 1'b0);
    guard = 0;
    while (m_tak < 65535 && guard < 70000) begin
      tick();
      guard++;
    end
    if (guard >= 70000) check("saturation_bound", 32'(guard), 32'd0);
    check("taken_at_max", 32'(taken_count), 32'h0000_FFFF);
    repeat (3) tick();
    check("taken_saturated", 32'(taken_count), 32'h0000_FFFF);

    // Asynchronous reset in HALT, then resume together with reset
    drive(HALT_I, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    check("pre_reset_halted", 32'(halted), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_halted_clear", 32'(halted), 32'd0);
    check("async_state_clear", 32'(state), 32'd0);
    check("async_retired_clear", retired_count, 32'd0);
    check("async_taken_clear", 32'(taken_count), 32'd0);
    drive(HALT_I, 1'b0, 1'b0, 1'b1);
    tick();
    check("reset_beats_resume", 32'(state), 32'd0);
    reset = 1'b0;
    drive(NOP_I, 1'b0, 1'b0, 1'b0);
    repeat (5) tick();
    check("rerun_retired", retired_count, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
